// File: rtl/mem_access_seq_if.sv
// Request and memory-bus signal bundle for the memory-access sequencer.
// master = pipeline/memory side, slave = the sequencer itself.
interface mem_access_seq_if #(
    parameter int ADDR_W = 20
);
    // Request side
    logic              req_valid;
    logic              mem_read;
    logic              mem_write;
    logic              en32;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              req_ready;
    logic              stall;
    logic              err;
    logic [31:0]       rdata;
    logic              rdata_valid;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    modport master (
        output req_valid, mem_read, mem_write, en32, addr, wdata, mem_rdata,
        input  req_ready, stall, err, rdata, rdata_valid,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  req_valid, mem_read, mem_write, en32, addr, wdata, mem_rdata,
        output req_ready, stall, err, rdata, rdata_valid,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_seq.sv
// Splits a 16/32-bit load or store into one or two 16-bit memory beats and
// assembles load data; freezes the pipeline while an access is in flight.
module mem_access_seq #(
    parameter int ADDR_W = 20
) (
    input  logic            clk,
    input  logic            reset,
    mem_access_seq_if.slave bus,
    output logic [1:0]      dbg_state
);
    // Handshake: a request is taken on a posedge where req_ready=1 and
    // req_valid=1 with exactly one of mem_read/mem_write; all request inputs
    // are don't-care whenever req_ready=0.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE0 = 2'd1,
        ISSUE1 = 2'd2,
        CAPT   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        is_load_q;
    logic        en32_q;
    logic [15:0] wdata_hi_q;
    logic [15:0] rdata_lo_q;
    logic        accept;
    logic        illegal;

    always_comb begin
        accept  = 1'b0;
        illegal = 1'b0;
        if (state_q == IDLE && bus.req_valid) begin
            accept  = bus.mem_read ^ bus.mem_write;
            illegal = bus.mem_read & bus.mem_write;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE0;
            end
            ISSUE0: begin
                if (en32_q)         state_d = ISSUE1;
                else if (is_load_q) state_d = CAPT;
                else                state_d = IDLE;
            end
            ISSUE1: begin
                state_d = is_load_q ? CAPT : IDLE;
            end
            CAPT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Memory strobes and address are registered one state ahead so they are
    // valid for the whole ISSUE cycle and hold their value afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= 16'h0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.err         <= 1'b0;
            bus.rdata       <= 32'h0;
            bus.rdata_valid <= 1'b0;
            wdata_hi_q      <= 16'h0;
            rdata_lo_q      <= 16'h0;
            is_load_q       <= 1'b0;
            en32_q          <= 1'b0;
        end else begin
            bus.err         <= illegal;
            bus.rdata_valid <= (state_q == CAPT);
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus.mem_addr  <= bus.addr;
                        bus.mem_wdata <= bus.wdata[15:0];
                        wdata_hi_q    <= bus.wdata[31:16];
                        en32_q        <= bus.en32;
                        is_load_q     <= bus.mem_read;
                        bus.mem_rd    <= bus.mem_read;
                        bus.mem_wr    <= bus.mem_write;
                    end
                end
                ISSUE0: begin
                    if (en32_q) begin
                        bus.mem_addr  <= bus.mem_addr + ADDR_W'(1);
                        bus.mem_wdata <= wdata_hi_q;
                        bus.mem_rd    <= is_load_q;
                        bus.mem_wr    <= ~is_load_q;
                    end
                end
                ISSUE1: begin
                    // Low half is staged so rdata keeps the previous load until this one completes.
                    if (is_load_q) rdata_lo_q <= bus.mem_rdata;
                end
                CAPT: begin
                    if (en32_q) bus.rdata <= {bus.mem_rdata, rdata_lo_q};
                    else        bus.rdata <= {16'h0, bus.mem_rdata};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.stall     = (state_q != IDLE);
    assign dbg_state     = state_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (!reset)
        !(bus.mem_rd && bus.mem_wr));
    a_err_quiet: assert property (@(posedge clk) disable iff (!reset)
        bus.err |-> !(bus.mem_rd || bus.mem_wr));
endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 Parameter ADDR_W, default 20, memory word-address width (16-bit memory words).
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  memory-stage request present.
REQ-005 mem_read  in  1  request is a load; from decoded control word.
REQ-006 mem_write  in  1  request is a store; from decoded control word.
REQ-007 en32  in  1  1 = 32-bit (two-beat) access, 0 = 16-bit access.
REQ-008 addr  in  ADDR_W  request word address.
REQ-009 wdata  in  32  store data; [15:0] used for 16-bit stores.
REQ-010 req_ready  out  1  sequencer idle, request accepted this cycle if req_valid.
REQ-011 stall  out  1  pipeline freeze while an access is in flight.
REQ-012 err  out  1  one-cycle pulse on illegal request.
REQ-013 mem_addr  out  ADDR_W  memory address.
REQ-014 mem_rd / mem_wr  out  1 each  memory read/write strobes.
REQ-015 mem_wdata  out  16  memory write halfword.
REQ-016 mem_rdata  in  16  memory read data, valid the cycle after mem_rd.
REQ-017 rdata  out  32  assembled load data.
REQ-018 rdata_valid  out  1  one-cycle pulse, rdata valid.

Function
REQ-019 States: IDLE, ISSUE0, ISSUE1, CAPT; state held in registers.
REQ-020 req_ready = (state==IDLE); stall = (state!=IDLE).
REQ-021 IDLE, req_valid, exactly one of mem_read/mem_write: latch addr, wdata, en32, op type; next ISSUE0.
REQ-022 IDLE, req_valid, both mem_read and mem_write: err=1 next cycle for one cycle, no memory strobe, stay IDLE.
REQ-023 IDLE, req_valid, neither strobe: ignored, stay IDLE, no err.
REQ-024 ISSUE0: mem_addr=latched addr, mem_wdata=wdata[15:0], mem_rd or mem_wr=1 per op; next ISSUE1 if en32, else CAPT if load, else IDLE.
REQ-025 ISSUE1: mem_addr=addr+1 modulo 2^ADDR_W (all-ones wraps to 0), mem_wdata=wdata[31:16], strobe per op; load captures mem_rdata into rdata[15:0]; next CAPT if load, else IDLE.
REQ-026 CAPT: no strobe; mem_rdata captured into rdata[31:16] if en32, else into rdata[15:0] with rdata[31:16]=0; next IDLE; rdata_valid=1 in the following cycle only.
REQ-027 Outside ISSUE0/ISSUE1: mem_rd=0, mem_wr=0; mem_addr and mem_wdata hold last value.
REQ-028 Latency from accept cycle T: 16-bit store strobe T+1, ready T+2; 32-bit store strobes T+1,T+2, ready T+3; 16-bit load valid T+3; 32-bit load valid T+4.
REQ-029 A new request is accepted in the same cycle rdata_valid pulses (back-to-back allowed).
REQ-030 Inputs other than clk/reset are ignored while state!=IDLE.
REQ-031 rdata holds its value until the next load completes.

Reset
REQ-032 reset low: state=IDLE, mem_rd=0, mem_wr=0, err=0, rdata_valid=0, rdata=0, mem_addr=0, mem_wdata=0, immediately without clk.
REQ-033 Reset mid-access aborts; completed beats are not rolled back; no rdata_valid issued for the aborted load.
REQ-034 First request is accepted on the first posedge after reset deasserts.

Verification
REQ-035 16-bit store addr=0x00010, wdata=0x0000BEEF -> one mem_wr at 0x00010 data 0xBEEF at T+1; stall high T+1; ready T+2.
REQ-036 32-bit load addr=0xFFFFF, memory 0xFFFFF=0x1234, 0x00000=0xABCD -> mem_rd at 0xFFFFF then 0x00000; rdata=0xABCD1234, rdata_valid at T+4.
REQ-037 32-bit store addr=0x00100, wdata=0xCAFE0001 -> mem_wr 0x00100/0x0001 then 0x00101/0xCAFE; no rdata_valid.
REQ-038 mem_read=mem_write=1 with req_valid -> err pulse one cycle, no strobes, ready stays 1.
REQ-039 reset low during ISSUE1 of 32-bit load -> strobes drop immediately, state IDLE, no rdata_valid; next load completes normally.
REQ-040 16-bit load then back-to-back 16-bit store in rdata_valid cycle -> rdata[31:16]=0, store accepted that cycle, strobe next cycle.
